// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               requesters with a registered valid/ready result channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_data,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic            r_last_grant;
  logic            r_owner;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            r_rsp0_valid;
  logic            r_rsp1_valid;
  logic [XLEN-1:0] r_rsp0_data;
  logic [XLEN-1:0] r_rsp1_data;
  logic            r_busy;

  logic            w_any_req;
  logic            w_grant;
  logic            w_accept;
  logic            w_rsp_taken;

  // Under contention the requester that did not win last goes first.
  always_comb begin
    w_any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1_valid;
    end
    w_accept    = (r_state == S_IDLE) && !flush && w_any_req;
    w_rsp_taken = r_owner ? rsp1_ready : rsp0_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept)    w_next_state = S_EXEC;
        S_EXEC:                   w_next_state = S_RESP;
        S_RESP:  if (w_rsp_taken) w_next_state = S_IDLE;
        default:                  w_next_state = S_IDLE;
      endcase
    end
  end

  // Output logic; ready is masked while reset is asserted.
  always_comb begin
    req0_ready = rst_n && w_accept && !w_grant;
    req1_ready = rst_n && w_accept &&  w_grant;
  end

  // Request latch, arbitration history and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= 4'h0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_op         <= w_grant ? req1_op : req0_op;
        r_a          <= w_grant ? req1_a  : req0_a;
        r_b          <= w_grant ? req1_b  : req0_b;
      end
      // Flush drops the result; captured data from earlier responses remains.
      if (flush) begin
        r_rsp0_valid <= 1'b0;
        r_rsp1_valid <= 1'b0;
      end else if (r_state == S_EXEC) begin
        if (r_owner) begin
          r_rsp1_valid <= 1'b1;
          r_rsp1_data  <= alu_result;
        end else begin
          r_rsp0_valid <= 1'b1;
          r_rsp0_data  <= alu_result;
        end
      end else if ((r_state == S_RESP) && w_rsp_taken) begin
        r_rsp0_valid <= 1'b0;
        r_rsp1_valid <= 1'b0;
      end
    end
  end

  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_data  = r_rsp1_data;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the core's single combinational ALU between two requesters (requester 0: execute path, requester 1: auxiliary unit, e.g. address generation or a multi-cycle sequencer). Each request carries a 4-bit ALU operation code, in the same encoding that `alu_control` produces, plus two operands. The block arbitrates round-robin, latches the winning request, drives the external ALU for one cycle and returns the registered result to the owner over a valid/ready response channel.

## Interface

Parameters:
- `XLEN`, 32, operand/result width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  4  ALU operation code.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  XLEN  operands.
- `alu_op`  out  4  operation code to the ALU.
- `alu_a`, `alu_b`  out  XLEN  operands to the ALU.
- `alu_result`  in  XLEN  combinational ALU result.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the result.
- `rsp0_data` / `rsp1_data`  out  XLEN  result.
- `busy`  out  1  high in any state other than IDLE.

## Operation

- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant the requester that did not win last. The `last_grant` register resets to 1, so requester 0 wins the first contest.
  - `reqN_ready` is combinational: `state==IDLE && grant==N`. Only the granted requester sees ready. At most one ready is high per cycle.
  - On handshake: latch op/a/b into internal registers, record `owner=N`, update `last_grant=N`, go to EXEC.
- **EXEC**
  - `alu_op`/`alu_a`/`alu_b` come from the latch registers. They always reflect the latched values and stay stable outside EXEC.
  - Capture `alu_result` into the response data register of `owner`, assert `rsp<owner>_valid`, go to RESP.
- **RESP**
  - Hold `rsp<owner>_valid` and data until `rsp<owner>_ready` is high, then deassert valid and go to IDLE.
  - No new request is accepted in RESP.
- The non-owner's `rspN_valid` is always 0. `rspN_data` holds its last captured value.
- Requester rules:
  - `reqN_valid` and its payload must stay stable until ready.
  - The arbiter does not sample the payload in cycles without a handshake.
- `flush` has priority over all transitions. In EXEC or RESP it:
  - forces IDLE;
  - clears both `rspN_valid`;
  - discards the result.
  - `last_grant` keeps the value updated at the handshake.
  - In IDLE, `flush` blocks acceptance that cycle: both ready are 0.
- The operation code passes through unmodified. The block performs no arithmetic. Widths match exactly and nothing is truncated or extended.

## Timing

- Reset values (asynchronous, while `rst_n`=0):
  - state=IDLE, `last_grant`=1;
  - `alu_op`=4'h0, `alu_a`=`alu_b`=0;
  - `rsp0_valid`=`rsp1_valid`=0, `rsp0_data`=`rsp1_data`=0;
  - `busy`=0.
  - `reqN_ready` is 0 during reset.
- Reset mid-operation (EXEC or RESP): everything returns to the reset values immediately. The in-flight result is lost.
- Latency:
  - handshake in cycle T;
  - ALU driven in cycle T+1;
  - `rspN_valid` high from cycle T+2.
- Minimum issue interval is 3 cycles, when the response is taken in its first valid cycle.
- `busy` is registered and high from T+1 until the cycle after the response handshake.
- Simultaneous events:
  - `rspN_ready` high in the same cycle valid first rises: completes the response that cycle.
  - `flush` together with `rsp_ready`: flush wins, and no response is counted.

## Test plan

- Reset then single request: `req0_valid`=1, op=4'h0, a=5, b=7 → `req0_ready` high in cycle 0, `alu_a`=5/`alu_b`=7 in cycle 1, `rsp0_valid`=1 with `rsp0_data`=12 (ALU model) in cycle 2, `rsp1_valid` stays 0.
- Contention fairness: both requesters held valid continuously for 4 transactions, `rsp_ready` always 1 → grant order 0,1,0,1, one transaction every 3 cycles.
- Response backpressure: `rsp1_ready`=0 for 5 cycles after valid → `rsp1_valid` and data held constant, `busy`=1, `req0_ready`=0 throughout; ready pulse → IDLE next cycle.
- Flush in EXEC and in RESP: both cases → `rsp*_valid`=0 the next cycle, state IDLE, the next request is granted to the opposite requester.
- Asynchronous reset asserted mid-RESP (between clock edges) → `rsp*_valid`, `busy` and `alu_*` go to 0 without a clock edge; after release, the first contest goes to requester 0.
- Payload stability: requester 1 changes a/b while waiting ungranted → only the values present at its handshake cycle appear on `alu_a`/`alu_b`.
